// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-box tables, GF(2^8) arithmetic, round constants,
// the forward key-expansion step and the decryptor FSM encoding.
package aes_pkg;

  typedef logic [127:0] block_t;  // 16 bytes, byte 0 in bits [127:120]

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    ROUND = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // One forward key-expansion step: rk_(i-1) -> rk_i.
  function automatic block_t ke_step_fwd(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/inv_ke_core.sv
// Inverse AES-128 key-expansion step: rk_i and its index i -> rk_(i-1).
module inv_ke_core
  import aes_pkg::*;
(
  input  logic [127:0] word_in,
  input  logic [3:0]   idx,
  output logic [127:0] word_out
);

  logic [31:0] w0, w1, w2, w3;

  // Undo the forward chain from the last word back to the first.
  always_comb begin
    w3 = word_in[31:0] ^ word_in[63:32];
    w2 = word_in[63:32] ^ word_in[95:64];
    w1 = word_in[95:64] ^ word_in[127:96];
    w0 = word_in[127:96] ^ sub_word(rot_word(w3)) ^ {rcon(idx), 24'h0};
    word_out = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor, one round per clock with on-the-fly round keys.
// Optional DEC_KEY_CACHE_EN caches rk10 so repeated keys skip the forward expansion.
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
`ifdef DEC_KEY_CACHE_EN
  input  logic         key_new,
`endif
  input  logic [127:0] key_in,
  input  logic [127:0] ct_in,
  input  logic         vin,
  output logic         ready,
  output logic [127:0] pt_out,
  output logic         vout
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_dec_iter supports only NR=10");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [3:0] FIRST_INV = 4'(NR - 1);

  state_t       fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   round_cnt_reg, round_cnt_next;
  logic [127:0] pt_reg, pt_next;
  logic         vout_reg, vout_next;

`ifdef DEC_KEY_CACHE_EN
  logic [127:0] cache_reg, cache_next;
  logic         cache_valid_reg, cache_valid_next;
`endif

  logic [127:0] fwd_key;
  logic [127:0] rk_prev;
  logic [127:0] isb_blk;
  logic [127:0] ark_blk;
  logic [127:0] imc_blk;

  assign fwd_key = ke_step_fwd(key_reg, rcon(round_cnt_reg));

  // key_reg holds rk_(r+1) during round r, so step back from index r+1.
  inv_ke_core u_inv_ke (
    .word_in  (key_reg),
    .idx      (round_cnt_reg + 4'd1),
    .word_out (rk_prev)
  );

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_isr
    localparam int SRC = (gi % 4) + 4 * (((gi / 4) - (gi % 4) + 4) % 4);
    assign isb_blk[127-8*gi -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]);
  end

  assign ark_blk = isb_blk ^ rk_prev;

  for (gi = 0; gi < 4; gi++) begin : g_imc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_blk[127-32*gi -: 8];
    assign a1 = ark_blk[119-32*gi -: 8];
    assign a2 = ark_blk[111-32*gi -: 8];
    assign a3 = ark_blk[103-32*gi -: 8];
    assign imc_blk[127-32*gi -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign imc_blk[119-32*gi -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign imc_blk[111-32*gi -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign imc_blk[103-32*gi -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      key_reg       <= '0;
      round_cnt_reg <= '0;
      pt_reg        <= '0;
      vout_reg      <= 1'b0;
`ifdef DEC_KEY_CACHE_EN
      cache_reg       <= '0;
      cache_valid_reg <= 1'b0;
`endif
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      key_reg       <= key_next;
      round_cnt_reg <= round_cnt_next;
      pt_reg        <= pt_next;
      vout_reg      <= vout_next;
`ifdef DEC_KEY_CACHE_EN
      cache_reg       <= cache_next;
      cache_valid_reg <= cache_valid_next;
`endif
    end
  end

  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    key_next       = key_reg;
    round_cnt_next = round_cnt_reg;
    pt_next        = pt_reg;
    vout_next      = 1'b0;
    ready          = (fsm_reg == IDLE);
`ifdef DEC_KEY_CACHE_EN
    cache_next       = cache_reg;
    cache_valid_next = cache_valid_reg;
`endif
    case (fsm_reg)
      IDLE: begin
        if (vin) begin
          state_next     = ct_in;
          key_next       = key_in;
          round_cnt_next = 4'd1;
          fsm_next       = KEXP;
`ifdef DEC_KEY_CACHE_EN
          if (!key_new && cache_valid_reg) begin
            state_next     = ct_in ^ cache_reg;
            key_next       = cache_reg;
            round_cnt_next = FIRST_INV;
            fsm_next       = ROUND;
          end
`endif
        end
      end
      KEXP: begin
        key_next       = fwd_key;
        round_cnt_next = round_cnt_reg + 4'd1;
        if (round_cnt_reg == LAST_RND) begin
          state_next     = state_reg ^ fwd_key;
          round_cnt_next = FIRST_INV;
          fsm_next       = ROUND;
`ifdef DEC_KEY_CACHE_EN
          cache_next       = fwd_key;
          cache_valid_next = 1'b1;
`endif
        end
      end
      ROUND: begin
        if (round_cnt_reg != 4'd0) begin
          state_next     = imc_blk;
          key_next       = rk_prev;
          round_cnt_next = round_cnt_reg - 4'd1;
        end else begin
          // Final round has no InvMixColumns.
          pt_next   = ark_blk;
          vout_next = 1'b1;
          fsm_next  = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign pt_out = pt_reg;
  assign vout   = vout_reg;

endmodule
